// File: rtl/multiplicador_secuencial.sv
// rtl/multiplicador_secuencial.sv - unsigned shift-and-add multiplier driving an external 32-bit adder
// One adder pass per cycle: the carry/sum pair becomes the new upper half while P shifts right.
module multiplicador_secuencial #(
  parameter int ANCHO = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inicio,
  input  logic [ANCHO-1:0]   multiplicando,
  input  logic [ANCHO-1:0]   multiplicador,
  output logic [ANCHO-1:0]   SumandoA,
  output logic [ANCHO-1:0]   SumandoB,
  output logic               Acarreo,
  input  logic [ANCHO-1:0]   Resultado,
  input  logic               SignoMasSignificativo,
  output logic               ocupado,
  output logic               listo,
  output logic [2*ANCHO-1:0] producto
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;
  localparam logic [CW-1:0] ULTIMA = CW'(ANCHO - 1);

  typedef enum logic [1:0] {
    REPOSO,
    SUMA,
    LISTO
  } estado_t;

  estado_t            estado;
  estado_t            estado_sig;
  logic [2*ANCHO-1:0] p;
  logic [2*ANCHO-1:0] p_sig;
  logic [ANCHO-1:0]   mreg;
  logic [CW-1:0]      contador;

  assign SumandoA = p[2*ANCHO-1:ANCHO];
  assign SumandoB = p[0] ? mreg : '0;
  assign Acarreo  = 1'b0;

  // Adder carry lands in the MSB, so no product bit is ever lost.
  assign p_sig = {SignoMasSignificativo, Resultado, p[ANCHO-1:1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    ocupado    = 1'b0;
    listo      = 1'b0;
    case (estado)
      REPOSO: begin
        if (inicio) estado_sig = SUMA;
      end
      SUMA: begin
        ocupado = 1'b1;
        if (contador == ULTIMA) estado_sig = LISTO;
      end
      LISTO: begin
        listo      = 1'b1;
        estado_sig = inicio ? SUMA : REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p        <= '0;
      mreg     <= '0;
      contador <= '0;
      producto <= '0;
    end else begin
      case (estado)
        REPOSO, LISTO: begin
          if (inicio) begin
            p        <= {{ANCHO{1'b0}}, multiplicador};
            mreg     <= multiplicando;
            contador <= '0;
          end
        end
        SUMA: begin
          p        <= p_sig;
          contador <= contador + CW'(1);
          if (contador == ULTIMA) producto <= p_sig;
        end
        default: begin
          p        <= p;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// tb/tb_multiplicador_secuencial.sv - self-checking bench for multiplicador_secuencial
// Supplies the combinational adder and compares against plain 64-bit multiplication.
module tb_multiplicador_secuencial;

  localparam int ANCHO = 32;
  localparam int LAT   = ANCHO + 1;
  localparam int LIMIT = 200;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               inicio;
  logic [ANCHO-1:0]   multiplicando;
  logic [ANCHO-1:0]   multiplicador;
  logic [ANCHO-1:0]   SumandoA;
  logic [ANCHO-1:0]   SumandoB;
  logic               Acarreo;
  logic [ANCHO-1:0]   Resultado;
  logic               SignoMasSignificativo;
  logic               ocupado;
  logic               listo;
  logic [2*ANCHO-1:0] producto;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {SignoMasSignificativo, Resultado} =
    {1'b0, SumandoA} + {1'b0, SumandoB} + {{ANCHO{1'b0}}, Acarreo};

  multiplicador_secuencial #(.ANCHO(ANCHO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .inicio(inicio),
    .multiplicando(multiplicando),
    .multiplicador(multiplicador),
    .SumandoA(SumandoA),
    .SumandoB(SumandoB),
    .Acarreo(Acarreo),
    .Resultado(Resultado),
    .SignoMasSignificativo(SignoMasSignificativo),
    .ocupado(ocupado),
    .listo(listo),
    .producto(producto)
  );

  function automatic logic [63:0] modelo(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {32'b0, a};
    eb = {32'b0, b};
    return ea * eb;
  endfunction

  // Pulse inicio for one cycle, then wait for listo; reports latency and busy cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy, output logic [63:0] prod);
    @(negedge clk);
    inicio = 1'b1;
    multiplicando = a;
    multiplicador = b;
    lat = 0;
    busy = 0;
    do begin
      @(negedge clk);
      inicio = 1'b0;
      lat++;
      if (ocupado) busy++;
    end while (!listo && lat < LIMIT);
    prod = producto;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    inicio = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
    checks++;
    if (listo !== 1'b0) begin errors++; $display("FAIL reset_listo got %b want 0", listo); end
    checks++;
    if (producto !== 64'd0) begin errors++; $display("FAIL reset_producto got %h want 0", producto); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, busy;
    logic [63:0] prod;
    run_op(32'd3, 32'd5, lat, busy, prod);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (busy !== ANCHO) begin errors++; $display("FAIL basic_busy got %0d want %0d", busy, ANCHO); end
    checks++;
    if (prod !== modelo(32'd3, 32'd5)) begin errors++; $display("FAIL basic_producto got %h want %h", prod, modelo(32'd3, 32'd5)); end
    @(negedge clk);
    checks++;
    if (listo !== 1'b0) begin errors++; $display("FAIL basic_listo_width got %b want 0", listo); end
    checks++;
    if (ocupado !== 1'b0) begin errors++; $display("FAIL basic_idle_ocupado got %b want 0", ocupado); end
  endtask

  task automatic test_corners();
    logic [31:0] as [3];
    logic [31:0] bs [3];
    int lat, busy;
    logic [63:0] prod;
    as[0] = 32'hFFFF_FFFF; bs[0] = 32'hFFFF_FFFF;
    as[1] = 32'h0;         bs[1] = 32'h1234_5678;
    as[2] = 32'h1234_5678; bs[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      run_op(as[i], bs[i], lat, busy, prod);
      checks++;
      if (prod !== modelo(as[i], bs[i])) begin errors++; $display("FAIL corner%0d_producto got %h want %h", i, prod, modelo(as[i], bs[i])); end
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL corner%0d_latency got %0d want %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_ignore_inicio();
    int cyc, pulses, first;
    @(negedge clk);
    inicio = 1'b1;
    multiplicando = 32'd7;
    multiplicador = 32'd9;
    pulses = 0;
    first = 0;
    for (cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      inicio = (cyc == 10);
      if (cyc == 10) begin
        multiplicando = 32'd100;
        multiplicador = 32'd200;
      end
      if (listo) begin
        pulses++;
        if (first == 0) begin
          first = cyc;
          checks++;
          if (producto !== modelo(32'd7, 32'd9)) begin errors++; $display("FAIL ignore_producto got %h want %h", producto, modelo(32'd7, 32'd9)); end
        end
      end
    end
    checks++;
    if (first !== LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", first, LAT); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_reset_abort();
    int lat, busy;
    logic [63:0] prod;
    @(negedge clk);
    inicio = 1'b1;
    multiplicando = 32'hABCD;
    multiplicador = 32'h1234;
    @(negedge clk);
    inicio = 1'b0;
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (ocupado !== 1'b0) begin errors++; $display("FAIL abort_ocupado got %b want 0", ocupado); end
    checks++;
    if (listo !== 1'b0) begin errors++; $display("FAIL abort_listo got %b want 0", listo); end
    checks++;
    if (producto !== 64'd0) begin errors++; $display("FAIL abort_producto got %h want 0", producto); end
    run_op(32'hABCD, 32'h1234, lat, busy, prod);
    checks++;
    if (prod !== modelo(32'hABCD, 32'h1234)) begin errors++; $display("FAIL abort_fresh_producto got %h want %h", prod, modelo(32'hABCD, 32'h1234)); end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL abort_fresh_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int lat, busy, gap, held_bad;
    logic [63:0] prod;
    run_op(32'd2, 32'd3, lat, busy, prod);
    checks++;
    if (prod !== modelo(32'd2, 32'd3)) begin errors++; $display("FAIL b2b_first got %h want %h", prod, modelo(32'd2, 32'd3)); end
    inicio = 1'b1;
    multiplicando = 32'd4;
    multiplicador = 32'd5;
    gap = 0;
    held_bad = 0;
    do begin
      @(negedge clk);
      inicio = 1'b0;
      gap++;
      if (!listo && producto !== modelo(32'd2, 32'd3)) held_bad++;
    end while (!listo && gap < LIMIT);
    checks++;
    if (gap !== LAT) begin errors++; $display("FAIL b2b_gap got %0d want %0d", gap, LAT); end
    checks++;
    if (held_bad !== 0) begin errors++; $display("FAIL b2b_held got %0d bad cycles want 0", held_bad); end
    checks++;
    if (producto !== modelo(32'd4, 32'd5)) begin errors++; $display("FAIL b2b_second got %h want %h", producto, modelo(32'd4, 32'd5)); end
  endtask

  task automatic test_random();
    int lat, busy;
    logic [63:0] prod;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) a = 32'hFFFF_FFFF;
      if (i % 7 == 2) b = 32'h8000_0000;
      run_op(a, b, lat, busy, prod);
      checks++;
      if (prod !== modelo(a, b) || lat !== LAT) begin
        errors++;
        $display("FAIL random%0d %h*%h got %h lat %0d want %h lat %0d", i, a, b, prod, lat, modelo(a, b), LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_inicio();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
